// File: rtl/reg3_rr_arbiter.sv
// Round-robin arbiter sharing one 3-bit register among NREQ requesters.
// Optional tenure extension via the lock port when ARB_LOCK_EN is defined.
module reg3_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int IW       = 2,
    parameter int HOLD_CYC = 2,
    parameter int CW       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] d,
`ifdef ARB_LOCK_EN
    input  logic              lock,
`endif
    output logic [NREQ-1:0]   grant,
    output logic              ack,
    output logic              busy,
    output logic [2:0]        q
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t          state_q;
    logic [2:0]      q_q;
    logic [NREQ-1:0] grant_q;
    logic            ack_q;
    logic            busy_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   sel_q;
    logic [CW-1:0]   cnt_q;

    logic [IW-1:0]   sel_d;
    logic            found_d;
    logic [IW:0]     sum_d;
    logic [IW-1:0]   ptr_d;
    logic            hold_ext;

`ifdef ARB_LOCK_EN
    assign hold_ext = lock;
`else
    assign hold_ext = 1'b0;
`endif

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        sel_d   = ptr_q;
        found_d = 1'b0;
        sum_d   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_d = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum_d >= (IW+1)'(NREQ))
                sum_d = sum_d - (IW+1)'(NREQ);
            if (!found_d && req[sum_d[IW-1:0]]) begin
                sel_d   = sum_d[IW-1:0];
                found_d = 1'b1;
            end
        end
    end

    assign ptr_d = (sel_q == IW'(NREQ-1)) ? '0 : sel_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= 3'b000;
            grant_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (found_d) begin
                        sel_q   <= sel_d;
                        grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << sel_d;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[sel_q]) begin
                        q_q   <= d[3*sel_q +: 3];
                        ack_q <= 1'b1;
                        if (HOLD_CYC == 0) begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            ptr_q   <= ptr_d;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= CW'(HOLD_CYC - 1);
                            state_q <= HOLD;
                        end
                    end else begin
                        // Requester withdrew before the write: release without touching q.
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    ack_q <= 1'b0;
                    if (cnt_q == '0) begin
                        if (!hold_ext) begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            ptr_q   <= ptr_d;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign q     = q_q;

endmodule

// File: tb/tb_reg3_rr_arbiter.sv
// Bench for reg3_rr_arbiter: directed scenarios then random traffic, checked
// against a cycle-timeline model of owner/start-cycle/pointer.
module tb_reg3_rr_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 2;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] d;
    logic [3:0]  grant;
    logic        ack;
    logic        busy;
    logic [2:0]  q;
`ifdef ARB_LOCK_EN
    logic        lock;
`endif

    reg3_rr_arbiter #(.NREQ(NREQ), .IW(2), .HOLD_CYC(HOLD), .CW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .d     (d),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .grant (grant),
        .ack   (ack),
        .busy  (busy),
        .q     (q)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Model: owner (-1 = none), cycle it was granted, rotation pointer.
    int         m_owner, m_start, m_cyc, m_ptr;
    logic [2:0] m_q;
    logic       m_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_start = 0; m_ptr = 0; m_q = 3'b000; m_ack = 1'b0;
    endtask

    task automatic m_release();
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
    endtask

    task automatic m_step(input logic [3:0] r, input logic [11:0] dd);
        m_cyc++;
        m_ack = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < NREQ; i++) begin
                int j;
                j = (m_ptr + i) % NREQ;
                if (m_owner < 0 && ((r >> j) & 4'd1) != 4'd0) begin
                    m_owner = j;
                    m_start = m_cyc;
                end
            end
        end else if (m_cyc == m_start + 1) begin
            if (((r >> m_owner) & 4'd1) != 4'd0) begin
                m_q   = 3'((dd >> (3 * m_owner)) & 12'h7);
                m_ack = 1'b1;
                if (HOLD == 0) m_release();
            end else begin
                m_release();
            end
        end else if (m_cyc >= m_start + 1 + HOLD) begin
            m_release();
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("grant", 32'(grant), 32'(eg));
        chk("ack",   32'(ack),   32'(m_ack));
        chk("busy",  32'(busy),  32'(m_owner >= 0));
        chk("q",     32'(q),     32'(m_q));
    endtask

    // Called at a negedge: drive, take one edge, compare at the next negedge.
    task automatic step(input logic [3:0] r, input logic [11:0] dd);
        req = r; d = dd;
        @(posedge clk);
        m_step(r, dd);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1 m_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_q",     32'(q),     32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] rr_seen[$];
    logic [3:0] rr_exp[5];
    logic [3:0] prev_g;

    initial begin
        clk = 1'b0; reset = 1'b1; req = '0; d = '0; m_cyc = 0;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        m_reset();
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // Reset during HOLD discards tenure; next grant starts at requester 0.
        step(4'b0001, 12'h005);
        chk("t1_grant", 32'(grant), 32'h1);
        step(4'b0001, 12'h005);
        chk("t1_q", 32'(q), 32'h5);
        step(4'b0001, 12'h005);
        async_reset();
        step(4'b1111, 12'hfff);
        chk("t1_next", 32'(grant), 32'h1);
        for (int i = 0; i < 3; i++) step(4'b0000, 12'h000);

        // Single request from requester 2.
        step(4'b0100, 12'h180);
        chk("t2_grant", 32'(grant), 32'h4);
        step(4'b0100, 12'h180);
        chk("t2_ack", 32'(ack), 32'h1);
        chk("t2_q",   32'(q),   32'h6);
        for (int i = 0; i < 3; i++) step(4'b0000, 12'h000);

        // Round robin with all requesting, from ptr = 0 after reset.
        async_reset();
        prev_g = '0;
        for (int i = 0; i < 20; i++) begin
            step(4'b1111, 12'(i * 37));
            if (grant != 4'b0 && prev_g == 4'b0) rr_seen.push_back(grant);
            prev_g = grant;
        end
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk("rr_count", 32'(rr_seen.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < rr_seen.size(); i++)
            chk("rr_order", 32'(rr_seen[i]), 32'(rr_exp[i]));
        for (int i = 0; i < 4; i++) step(4'b0000, 12'h000);

        // Cancel, then rotation resumes after the cancelled requester; then wrap.
        async_reset();
        step(4'b0010, 12'h038);
        chk("t4_grant", 32'(grant), 32'h2);
        step(4'b0000, 12'h038);
        chk("t4_ack", 32'(ack), 32'h0);
        chk("t4_q",   32'(q),   32'h0);
        step(4'b0110, 12'h1c0);
        chk("t4_next", 32'(grant), 32'h4);
        for (int i = 0; i < 3; i++) step(4'b0110, 12'h1c0);
        step(4'b1001, 12'ha03);
        chk("t5_wrap3", 32'(grant), 32'h8);
        for (int i = 0; i < 3; i++) step(4'b1001, 12'ha03);
        step(4'b1001, 12'ha03);
        chk("t5_wrap0", 32'(grant), 32'h1);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            step(r, 12'($urandom));
            if ($urandom_range(0, 59) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
